// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and helpers for the multi-port register file
package regfile_pkg;

  typedef enum logic {RF_CLEAR = 1'b0, RF_IDLE = 1'b1} rf_state_e;

  // Address width for a HARTS x REGS array; never narrower than one bit.
  function automatic int rf_aw(input int harts, input int regs);
    return (harts * regs > 1) ? $clog2(harts * regs) : 1;
  endfunction

  // Register-index field of a {hart, reg} address (REGS is a power of two).
  function automatic logic [31:0] rf_reg_field(input logic [31:0] addr, input int regs);
    return addr & 32'(regs - 1);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// rtl/regfile_mp_if.sv - register file access bus
// Ports: clear_req/ready (clear control), raddr/rden/rdata (packed read ports),
//        waddr/wdata/wren (single write port).
interface regfile_mp_if #(
  parameter int WIDTH      = 32,
  parameter int HARTS      = 4,
  parameter int REGS       = 32,
  parameter int READ_PORTS = 2
);
  localparam int AW = regfile_pkg::rf_aw(HARTS, REGS);

  logic                        clear_req;
  logic                        ready;
  logic [READ_PORTS*AW-1:0]    raddr;
  logic [READ_PORTS-1:0]       rden;
  logic [READ_PORTS*WIDTH-1:0] rdata;
  logic [AW-1:0]               waddr;
  logic [WIDTH-1:0]            wdata;
  logic                        wren;

  modport master (output clear_req, raddr, rden, waddr, wdata, wren,
                  input  ready, rdata);
  modport slave  (input  clear_req, raddr, rden, waddr, wdata, wren,
                  output ready, rdata);
endinterface

// File: rtl/regfile_clear_seq.sv
// rtl/regfile_clear_seq.sv - array clear sequencer
// Ports: clock, reset_n, clear_req_i (start clear when idle), ready_o (array usable),
//        clr_we_o / clr_addr_o (zero-write port into the array while clearing).
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          clear_req_i,
  output logic          ready_o,
  output logic          clr_we_o,
  output logic [AW-1:0] clr_addr_o
);

  rf_state_e     state_q;
  logic [AW-1:0] cnt_q;
  logic          ready_q;

  // Reset always lands in CLEAR so the array is zeroed by hardware,
  // taking exactly DEPTH cycles before ready rises.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RF_CLEAR;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        RF_CLEAR: begin
          // clear_req is deliberately ignored here: no restart mid-clear.
          if (cnt_q == AW'(DEPTH - 1)) begin
            state_q <= RF_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + AW'(1);
          end
        end
        RF_IDLE: begin
          if (clear_req_i) begin
            state_q <= RF_CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
          end
        end
        default: begin
          state_q <= RF_CLEAR;
          cnt_q   <= '0;
          ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign clr_we_o   = (state_q == RF_CLEAR);
  assign clr_addr_o = cnt_q;

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-hart, multi-read-port register file with write bypass
// Ports: clock, reset_n (async active-low), bus (regfile_mp_if slave: clear control,
//        READ_PORTS registered read ports, one write port).
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int HARTS      = 4,
  parameter int REGS       = 32,
  parameter int READ_PORTS = 2,
  parameter int ZERO_REG   = 1
) (
  input  logic         clock,
  input  logic         reset_n,
  regfile_mp_if.slave  bus
);

  localparam int AW    = rf_aw(HARTS, REGS);
  localparam int DEPTH = HARTS * REGS;

  logic [WIDTH-1:0]            mem_q [DEPTH];
  logic [READ_PORTS*WIDTH-1:0] rdata_q;
  logic [READ_PORTS*WIDTH-1:0] rdata_d;

  logic          ready;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic          ext_we;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_wdata;

  function automatic logic is_zero_reg(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (rf_reg_field(32'(a), REGS) == 32'd0);
  endfunction

  regfile_clear_seq #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_seq (
    .clock       (clock),
    .reset_n     (reset_n),
    .clear_req_i (bus.clear_req),
    .ready_o     (ready),
    .clr_we_o    (clr_we),
    .clr_addr_o  (clr_addr)
  );

  // Single array write port: the sequencer owns it while clearing,
  // otherwise external writes (minus writes to a hardwired zero reg).
  assign ext_we    = ready && bus.wren && !is_zero_reg(bus.waddr);
  assign mem_we    = clr_we || ext_we;
  assign mem_waddr = clr_we ? clr_addr : bus.waddr;
  assign mem_wdata = clr_we ? '0 : bus.wdata;

  // No reset on the array; contents survive reset until the clear rewrites them.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Priority per enabled port: clearing -> 0, zero reg -> 0, bypass, array.
  always_comb begin : read_mux
    logic [AW-1:0] ra;
    ra      = '0;
    rdata_d = rdata_q;
    for (int p = 0; p < READ_PORTS; p++) begin
      if (bus.rden[p]) begin
        ra = bus.raddr[p*AW +: AW];
        if (!ready || is_zero_reg(ra)) begin
          rdata_d[p*WIDTH +: WIDTH] = '0;
        end else if (ext_we && (bus.waddr == ra)) begin
          rdata_d[p*WIDTH +: WIDTH] = bus.wdata;
        end else begin
          rdata_d[p*WIDTH +: WIDTH] = mem_q[ra];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign bus.ready = ready;
  assign bus.rdata = rdata_q;

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed self-checking bench for regfile_mp
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_mp_if bus_a ();
  regfile_mp_if bus_b ();

  regfile_mp dut_a (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_a.slave)
  );

  regfile_mp #(.ZERO_REG(0)) dut_b (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus_b.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [6:0] a0, input logic [6:0] a1, input logic [1:0] en);
    bus_a.raddr = {a1, a0};
    bus_a.rden  = en;
  endtask

  task automatic wr(input logic en, input logic [6:0] a, input logic [31:0] d);
    bus_a.wren  = en;
    bus_a.waddr = a;
    bus_a.wdata = d;
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 128; a++) begin
      set_rd(7'(a), 7'(127 - a), 2'b11);
      tick();
      chk({tag, "_p0"}, bus_a.rdata[31:0], 32'h0);
      chk({tag, "_p1"}, bus_a.rdata[63:32], 32'h0);
    end
  endtask

  initial begin
    bus_a.clear_req = 1'b0;
    bus_b.clear_req = 1'b0;
    bus_b.raddr = '0;
    bus_b.rden  = '0;
    bus_b.waddr = '0;
    bus_b.wdata = '0;
    bus_b.wren  = 1'b0;
    set_rd(7'h0, 7'h0, 2'b00);
    wr(1'b0, 7'h0, 32'h0);

    // Reset state
    repeat (3) tick();
    chk("rst_ready", 32'(bus_a.ready), 32'h0);
    chk("rst_rdata0", bus_a.rdata[31:0], 32'h0);
    chk("rst_rdata1", bus_a.rdata[63:32], 32'h0);

    // Release: ready must rise after exactly 128 cycles; reads during clear give 0
    rst_n = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      set_rd(7'(i - 1), 7'(128 - i), 2'b11);
      tick();
      chk("init_ready", 32'(bus_a.ready), 32'(i == 128));
      chk("init_rd0", bus_a.rdata[31:0], 32'h0);
    end
    chk("init_ready_b", 32'(bus_b.ready), 32'h1);
    read_all_zero("init_all");

    // Write then read back; other hart's entry stays zero
    set_rd(7'h0, 7'h0, 2'b00);
    wr(1'b1, 7'h25, 32'hDEADBEEF);
    tick();
    wr(1'b0, 7'h0, 32'h0);
    set_rd(7'h25, 7'h45, 2'b11);
    tick();
    chk("wr_rd_25", bus_a.rdata[31:0], 32'hDEADBEEF);
    chk("wr_rd_45", bus_a.rdata[63:32], 32'h0);

    // Same-cycle bypass on both ports
    wr(1'b1, 7'h07, 32'h12345678);
    set_rd(7'h07, 7'h07, 2'b11);
    tick();
    chk("byp_p0", bus_a.rdata[31:0], 32'h12345678);
    chk("byp_p1", bus_a.rdata[63:32], 32'h12345678);
    wr(1'b0, 7'h0, 32'h0);
    tick();
    chk("byp_after_p0", bus_a.rdata[31:0], 32'h12345678);

    // Zero register: hart 1 reg 0
    wr(1'b1, 7'h20, 32'hFFFFFFFF);
    set_rd(7'h20, 7'h07, 2'b01);
    bus_b.wren  = 1'b1;
    bus_b.waddr = 7'h20;
    bus_b.wdata = 32'hFFFFFFFF;
    bus_b.raddr = {7'h0, 7'h20};
    bus_b.rden  = 2'b01;
    tick();
    chk("zr_byp_a", bus_a.rdata[31:0], 32'h0);
    chk("zr_byp_b", bus_b.rdata[31:0], 32'hFFFFFFFF);
    wr(1'b0, 7'h0, 32'h0);
    bus_b.wren = 1'b0;
    tick();
    chk("zr_later_a", bus_a.rdata[31:0], 32'h0);
    chk("zr_later_b", bus_b.rdata[31:0], 32'hFFFFFFFF);

    // rden low holds a port while the other tracks writes
    set_rd(7'h07, 7'h07, 2'b11);
    tick();
    chk("hold_pre", bus_a.rdata[63:32], 32'h12345678);
    for (int k = 1; k <= 3; k++) begin
      wr(1'b1, 7'h07, 32'(k * 32'h111));
      set_rd(7'h07, 7'h07, 2'b01);
      tick();
      chk("hold_track0", bus_a.rdata[31:0], 32'(k * 32'h111));
      chk("hold_p1", bus_a.rdata[63:32], 32'h12345678);
    end
    wr(1'b0, 7'h0, 32'h0);

    // Fill a few entries, then request a clear
    for (int k = 0; k < 4; k++) begin
      wr(1'b1, 7'(8'h10 + k), 32'hA0 + 32'(k));
      tick();
    end
    wr(1'b0, 7'h0, 32'h0);
    set_rd(7'h11, 7'h25, 2'b11);
    tick();
    chk("fill_rd", bus_a.rdata[31:0], 32'hA1);
    bus_a.clear_req = 1'b1;
    tick();
    bus_a.clear_req = 1'b0;
    chk("clr_ready_drop", 32'(bus_a.ready), 32'h0);
    for (int i = 1; i <= 128; i++) begin
      bus_a.clear_req = (i == 60);
      if (i == 100) wr(1'b1, 7'h30, 32'hAAAA5555);
      else wr(1'b0, 7'h0, 32'h0);
      set_rd(7'h07, 7'h25, 2'b11);
      tick();
      chk("clr_ready", 32'(bus_a.ready), 32'(i == 128));
      chk("clr_rd0", bus_a.rdata[31:0], 32'h0);
      chk("clr_rd1", bus_a.rdata[63:32], 32'h0);
    end
    bus_a.clear_req = 1'b0;
    wr(1'b0, 7'h0, 32'h0);
    read_all_zero("clr_all");

    // Reset in the middle of a clear restarts the full count
    wr(1'b1, 7'h33, 32'h55);
    set_rd(7'h33, 7'h0, 2'b01);
    tick();
    wr(1'b0, 7'h0, 32'h0);
    set_rd(7'h0, 7'h0, 2'b00);
    chk("mid_pre", bus_a.rdata[31:0], 32'h55);
    bus_a.clear_req = 1'b1;
    tick();
    bus_a.clear_req = 1'b0;
    repeat (50) tick();
    chk("mid_hold", bus_a.rdata[31:0], 32'h55);
    chk("mid_ready", 32'(bus_a.ready), 32'h0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdata", bus_a.rdata[31:0], 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 1; i <= 128; i++) begin
      tick();
      chk("mid_ready_cnt", 32'(bus_a.ready), 32'(i == 128));
    end
    set_rd(7'h33, 7'h11, 2'b11);
    tick();
    chk("mid_after_33", bus_a.rdata[31:0], 32'h0);
    chk("mid_after_11", bus_a.rdata[63:32], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-hart, multi-read-port register file for the pinwheel barrel core.
- Replaces the fixed 2-read/1-write, 1024-entry file.
- Address is {hart, reg}. Reads are registered (1-cycle latency) with same-cycle write bypass. Reg 0 is optionally hardwired to zero.
- A hardware clear sequencer zeroes the whole array after reset or on request, so behaviour does not depend on simulator initial blocks.

Parameters:
- WIDTH, 32, data word width in bits.
- HARTS, 4, number of hart banks; power of two, >=1.
- REGS, 32, registers per hart; power of two, >=2.
- READ_PORTS, 2, number of independent read ports, 1..4.
- ZERO_REG, 1, when 1, reg index 0 of every hart reads 0 and ignores writes.
- Derived, not overridable: AW = clog2(HARTS*REGS); DEPTH = HARTS*REGS.

Ports:
- clock  in  1  global clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clear_req  in  1  pulse; starts a full-array clear when idle.
- ready  out  1  high when the array is usable (not clearing).
- raddr  in  READ_PORTS*AW  packed read addresses; port p at [p*AW +: AW].
- rden  in  READ_PORTS  per-port read enable; when low, that port's output holds.
- rdata  out  READ_PORTS*WIDTH  packed registered read data.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wren  in  1  write enable.

Behaviour:
- Reset (reset_n low, asynchronous):
  - rdata = 0, ready = 0.
  - Clear counter = 0, state = CLEAR.
  - Array contents are not touched asynchronously.
- State machine has two states, CLEAR and IDLE.
  - CLEAR: each cycle writes 0 to array[counter] and increments counter. When counter == DEPTH-1 the write occurs, then state goes to IDLE and ready rises next cycle. This takes exactly DEPTH cycles from reset release to ready=1.
  - IDLE: ready = 1. clear_req=1 goes to CLEAR with counter=0; ready drops the following cycle.
  - clear_req during CLEAR is ignored; it does not restart the counter.
- During CLEAR:
  - External writes are dropped.
  - rdata ports with rden=1 load 0.
- Read, in IDLE with rden[p]=1:
  - At the clock edge, rdata[p] <= array[raddr[p]].
  - If wren && waddr == raddr[p], rdata[p] <= wdata (bypass; new data wins).
  - If ZERO_REG and reg field of raddr[p] == 0, rdata[p] <= 0, overriding the bypass.
- Read with rden[p]=0: rdata[p] holds its previous value, including during CLEAR.
- Write, in IDLE with wren=1: array[waddr] <= wdata at the edge. Dropped if ZERO_REG and reg field == 0.
- Multiple read ports may address the same entry. All receive identical data, with the same bypass applied.
- Reg field is waddr/raddr[log2(REGS)-1:0]; hart field is the upper bits. Addresses are always in range because DEPTH is a power of two.
- Reset asserted mid-CLEAR restarts the clear from 0. Reset mid-IDLE forces CLEAR. Array contents persist until overwritten.

Decomposition:
- Package regfile_pkg holds:
  - a clog2-based AW helper function;
  - the state enum {RF_CLEAR, RF_IDLE};
  - a reg-field extract function.
- One sub-module, regfile_clear_seq, owns the counter, state register, ready output, and clear write address/enable.
- The array, read ports and bypass stay in regfile_mp. The array has one write port, muxed between the sequencer and the external write.

Test Plan:
- Reset release (defaults: HARTS=4, REGS=32, DEPTH=128) -> ready stays 0 for 128 cycles, then 1. A read of every address during and after returns 0.
- Write 0xDEADBEEF to addr 0x25 (hart 1, reg 5); next cycle read port 0 at 0x25 -> rdata[0] = 0xDEADBEEF one cycle later. Port 1 reading 0x45 -> 0.
- Same cycle: wren, waddr=0x07, wdata=0x12345678; raddr0=raddr1=0x07 -> both ports show 0x12345678 next cycle (bypass).
- ZERO_REG=1: write 0xFFFFFFFF to addr 0x20 -> a read of 0x20 gives 0, both bypass-cycle and later. With ZERO_REG=0 the same sequence gives 0xFFFFFFFF.
- rden[1]=0 for 3 cycles while the array changes -> rdata[1] stays at its last value. rden[0]=1 tracks the writes.
- clear_req in IDLE after filling entries -> ready falls, 128 cycles of zero reads, all entries read 0 afterwards. Asserting reset_n=0 at cycle 50 of the clear restarts the full 128-cycle count.
